// File: rtl/median_map_writer.sv
// ---------------------------------------------------------------------------
// median_map_writer
//
// Packs the per-window majority bits of a column-major window scan into
// WORD_WIDTH-bit words, one group of WORDS_PER_COL words per window column,
// and streams them to the median result memory through a small FIFO. The FIFO
// decouples memory back-pressure from the scan: the scan never stalls, and a
// word that finds the FIFO full is dropped (and flagged) while the counters
// keep advancing so later words still land at the correct addresses.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      level enable; win_valid is ignored while low
//   win_valid  one-cycle strobe per completed window
//   win_bit    window majority result, sampled with win_valid
//   mem_addr   address of the FIFO head word (holds when FIFO empty)
//   mem_data   FIFO head word (holds when FIFO empty)
//   mem_we     write request, high whenever the FIFO is non-empty
//   mem_ready  memory accepts the head word when mem_we && mem_ready
//   map_done   sticky: the whole map has left the FIFO
//   overflow   sticky: at least one word was dropped (cleared by reset only)
//   busy       frame in progress or FIFO non-empty
// ---------------------------------------------------------------------------
module median_map_writer #(
    parameter int MAP_WIDTH     = 80,
    parameter int MAP_HEIGHT    = 60,
    parameter int WORD_WIDTH    = 16,
    parameter int WORDS_PER_COL = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int ADDR_WIDTH    = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  win_valid,
    input  logic                  win_bit,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic                  mem_ready,
    output logic                  map_done,
    output logic                  overflow,
    output logic                  busy
);

    localparam int CX_W  = $clog2(MAP_WIDTH);
    localparam int CY_W  = $clog2(MAP_HEIGHT);
    localparam int BI_W  = $clog2(WORD_WIDTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0] data;
    } entry_t;

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [CX_W-1:0]       cx_q, cx_d;
    logic [CY_W-1:0]       cy_q, cy_d;
    logic [BI_W-1:0]       bit_idx_q, bit_idx_d;
    logic [WORD_WIDTH-1:0] pack_q, pack_d;
    logic                  last_q, last_d;     // final word of frame pushed, awaiting drain
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    entry_t                fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_q, rd_d;
    logic [PTR_W-1:0]      wr_q, wr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    entry_t                head_q, head_d;     // registered copy of the FIFO head

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                  accept;
    logic                  cy_last, cx_last, bit_last;
    logic                  frame_wrap;
    logic                  push, pop, push_ok, drop;
    logic                  fifo_empty, fifo_full;
    logic [WORD_WIDTH-1:0] pack_merged;
    entry_t                push_entry;

    assign accept     = win_valid && start;
    assign cy_last    = (cy_q == CY_W'(MAP_HEIGHT - 1));
    assign cx_last    = (cx_q == CX_W'(MAP_WIDTH - 1));
    assign bit_last   = (bit_idx_q == BI_W'(WORD_WIDTH - 1));
    assign frame_wrap = accept && cy_last && cx_last;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));

    // Current bit merged into the pack register so a completing accept can
    // push the whole word in the same cycle.
    assign pack_merged = pack_q | (WORD_WIDTH'(win_bit) << bit_idx_q);

    // Word address: column base plus word index within the column.
    assign push_entry.addr = ADDR_WIDTH'(cx_q) * ADDR_WIDTH'(WORDS_PER_COL)
                           + ADDR_WIDTH'(cy_q >> BI_W);
    assign push_entry.data = pack_merged;

    // A short last word of the column is pushed at cy==MAP_HEIGHT-1; its
    // upper bits are zero because the pack register was cleared after the
    // previous push.
    assign push    = accept && (bit_last || cy_last);
    assign pop     = mem_we && mem_ready;
    // A pop in the same cycle frees the slot for a push into a full FIFO.
    assign push_ok = push && (!fifo_full || pop);
    assign drop    = push && fifo_full && !pop;

    // ------------------------------------------------------------------
    // Scan counters and pack register
    // ------------------------------------------------------------------
    always_comb begin
        cx_d      = cx_q;
        cy_d      = cy_q;
        bit_idx_d = bit_idx_q;
        pack_d    = pack_q;
        if (accept) begin
            if (push) begin
                pack_d    = '0;
                bit_idx_d = '0;
            end else begin
                pack_d    = pack_merged;
                bit_idx_d = bit_idx_q + BI_W'(1);
            end
            if (cy_last) begin
                cy_d = '0;
                cx_d = cx_last ? '0 : cx_q + CX_W'(1);
            end else begin
                cy_d = cy_q + CY_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Completion / overflow flags
    // ------------------------------------------------------------------
    always_comb begin
        last_d = last_q;
        done_d = done_q;
        ovf_d  = ovf_q | drop;
        // Completion waits until every word of the frame has left the FIFO.
        if (last_q && fifo_empty) begin
            done_d = 1'b1;
            last_d = 1'b0;
        end else if (accept && cx_q == '0 && cy_q == '0) begin
            done_d = 1'b0;
        end
        if (frame_wrap) begin
            last_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and registered head
    // ------------------------------------------------------------------
    always_comb begin
        rd_d   = rd_q + PTR_W'(pop);
        wr_d   = wr_q + PTR_W'(push_ok);
        cnt_d  = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
        head_d = head_q;
        if (cnt_d != '0) begin
            // When the next head is the word being written this cycle it is
            // not yet in storage, so forward it directly.
            if (push_ok && (rd_d == wr_q)) begin
                head_d = push_entry;
            end else begin
                head_d = fifo_q[rd_d];
            end
        end
    end

    // FIFO storage carries no reset; only entries below the count are read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[wr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cx_q      <= '0;
            cy_q      <= '0;
            bit_idx_q <= '0;
            pack_q    <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rd_q      <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
            head_q    <= '0;
        end else begin
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            bit_idx_q <= bit_idx_d;
            pack_q    <= pack_d;
            last_q    <= last_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            head_q    <= head_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_addr = head_q.addr;
    assign mem_data = head_q.data;
    assign mem_we   = !fifo_empty;
    assign map_done = done_q;
    assign overflow = ovf_q;
    assign busy     = (cx_q != '0) || (cy_q != '0) || !fifo_empty;

endmodule

// File: tb/tb_median_map_writer.sv
module tb_median_map_writer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, win_valid = 1'b0, win_bit = 1'b0, mem_ready = 1'b0;
    logic [8:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_we, map_done, overflow, busy;

    median_map_writer dut (
        .clk(clk), .reset(reset), .start(start), .win_valid(win_valid),
        .win_bit(win_bit), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_we(mem_we), .mem_ready(mem_ready), .map_done(map_done),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct { logic [8:0] a; logic [15:0] d; } wr_t;
    wr_t wr_log[$];   // words the DUT handed to memory

    // ---------------- behavioural reference model ----------------
    // Frame position is a single accept index n (0..4799); row/column and
    // word placement follow from plain arithmetic, the FIFO is a queue.
    wr_t         mq[$];
    int          n;
    logic [15:0] mword;
    logic [8:0]  h_a;
    logic [15:0] h_d;
    bit          m_ovf, m_done, m_last;

    task automatic model_reset();
        n = 0; mword = 0; mq.delete(); h_a = 0; h_d = 0;
        m_ovf = 0; m_done = 0; m_last = 0;
    endtask

    task automatic model_edge(input bit v, input bit b, input bit s, input bit r);
        bit pop, acc, push, emp, lp;
        wr_t e, x;
        int row, col;
        emp = (mq.size() == 0);
        lp = m_last;
        pop = !emp && r;
        acc = v && s;
        push = 0;
        e.a = 0; e.d = 0;
        if (lp && emp) begin m_done = 1; m_last = 0; end
        else if (acc && n == 0) m_done = 0;
        if (acc) begin
            row = n % 60; col = n / 60;
            if (b) mword[row % 16] = 1'b1;
            if (row % 16 == 15 || row == 59) begin
                push = 1; e.a = 9'(col * 4 + row / 16); e.d = mword; mword = 0;
            end
            n = (n + 1) % 4800;
            if (n == 0) m_last = 1;
        end
        if (pop) x = mq.pop_front();
        if (push) begin
            if (mq.size() < 4) mq.push_back(e);
            else m_ovf = 1;
        end
        if (mq.size() > 0) begin h_a = mq[0].a; h_d = mq[0].d; end
    endtask

    // One clock: drive inputs, log a DUT write, clock, update model, settle.
    task automatic step(input bit v, input bit b, input bit s, input bit r);
        win_valid = v; win_bit = b; start = s; mem_ready = r;
        if (mem_we && r) wr_log.push_back('{a: mem_addr, d: mem_data});
        @(posedge clk);
        model_edge(v, b, s, r);
        #1;
    endtask

    task automatic apply_reset();
        reset = 0; start = 0; win_valid = 0; win_bit = 0; mem_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        wr_log.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 0; start = 0; win_valid = 0; mem_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", mem_we); end
        vectors++; if (mem_addr !== 9'd0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
        vectors++; if (mem_data !== 16'd0) begin miscompares++; $display("FAIL reset_data: got %h want 0000", mem_data); end
        vectors++; if (map_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", map_done); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        apply_reset();
    endtask

    task automatic test_single_word();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 1, 1);
            if (i == 14) begin
                vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL word_early_we: got %b want 0", mem_we); end
            end
        end
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL word_we: got %b want 1", mem_we); end
        vectors++; if (mem_addr !== 9'd0) begin miscompares++; $display("FAIL word_addr: got %0d want 0", mem_addr); end
        vectors++; if (mem_data !== 16'hFFFF) begin miscompares++; $display("FAIL word_data: got %h want ffff", mem_data); end
        repeat (5) step(0, 0, 1, 1);
        vectors++; if (wr_log.size() != 1) begin miscompares++; $display("FAIL word_count: got %0d want 1", wr_log.size()); end
    endtask

    task automatic test_alternate();
        logic [15:0] exp_d[4];
        exp_d[0] = 16'h5555; exp_d[1] = 16'h5555; exp_d[2] = 16'h5555; exp_d[3] = 16'h0555;
        apply_reset();
        for (int i = 0; i < 60; i++) step(1, (i % 2) == 0, 1, 1);
        repeat (3) step(0, 0, 1, 1);
        vectors++;
        if (wr_log.size() != 4) begin miscompares++; $display("FAIL alt_count: got %0d want 4", wr_log.size()); end
        else for (int k = 0; k < 4; k++) begin
            if (wr_log[k].a !== 9'(k) || wr_log[k].d !== exp_d[k]) begin
                miscompares++;
                $display("FAIL alt_word%0d: got addr %0d data %h want addr %0d data %h", k, wr_log[k].a, wr_log[k].d, k, exp_d[k]);
            end
        end
        for (int i = 0; i < 76; i++) step(1, 1, 1, 1);
        repeat (3) step(0, 0, 1, 1);
        vectors++;
        if (wr_log.size() != 9) begin miscompares++; $display("FAIL col2_count: got %0d want 9", wr_log.size()); end
        else if (wr_log[8].a !== 9'd8 || wr_log[8].d !== 16'hFFFF) begin
            miscompares++; $display("FAIL col2_addr: got addr %0d data %h want addr 8 data ffff", wr_log[8].a, wr_log[8].d);
        end
    endtask

    task automatic test_start_gate();
        apply_reset();
        for (int i = 0; i < 10; i++) step(1, 1, 1, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1);
        vectors++; if (busy !== 1'b1 || mem_we !== 1'b0) begin miscompares++; $display("FAIL gate_hold: got busy %b we %b want busy 1 we 0", busy, mem_we); end
        for (int i = 0; i < 6; i++) step(1, 1, 1, 1);
        repeat (2) step(0, 0, 1, 1);
        vectors++;
        if (wr_log.size() != 1 || wr_log[0].a !== 9'd0 || wr_log[0].d !== 16'hFFFF) begin
            miscompares++; $display("FAIL gate_resume: got %0d writes (first %h) want 1 write ffff", wr_log.size(), (wr_log.size() > 0) ? wr_log[0].d : 16'h0);
        end
    endtask

    task automatic test_full_frame();
        int bad;
        apply_reset();
        for (int i = 0; i < 4800; i++) step(1, 1, 1, 1);
        step(0, 0, 1, 1);
        vectors++; if (map_done !== 1'b0) begin miscompares++; $display("FAIL frame_done_early: got %b want 0", map_done); end
        step(0, 0, 1, 1);
        vectors++; if (map_done !== 1'b1) begin miscompares++; $display("FAIL frame_done: got %b want 1", map_done); end
        bad = 0;
        for (int k = 0; k < wr_log.size(); k++)
            if (wr_log[k].a !== 9'(k) || wr_log[k].d !== ((k % 4 == 3) ? 16'h0FFF : 16'hFFFF)) bad++;
        vectors++; if (wr_log.size() != 320 || bad != 0) begin miscompares++; $display("FAIL frame_writes: got %0d writes %0d wrong want 320 writes 0 wrong", wr_log.size(), bad); end
        vectors++; if (overflow !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL frame_flags: got ovf %b busy %b want 0 0", overflow, busy); end
        step(1, 1, 1, 1);
        vectors++; if (map_done !== 1'b0) begin miscompares++; $display("FAIL frame_done_clear: got %b want 0", map_done); end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 1; i <= 80; i++) begin
            step(1, 1, 1, 0);
            if (i == 75) begin
                vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early: got %b want 0", overflow); end
            end
        end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b want 1", overflow); end
        vectors++; if (mem_addr !== 9'd0 || mem_we !== 1'b1) begin miscompares++; $display("FAIL ovf_hold: got addr %0d we %b want addr 0 we 1", mem_addr, mem_we); end
        repeat (6) step(0, 0, 1, 1);
        vectors++;
        if (wr_log.size() != 4 || wr_log[3].a !== 9'd3 || wr_log[3].d !== 16'h0FFF) begin
            miscompares++; $display("FAIL ovf_drain: got %0d writes want 4 ending addr 3 data 0fff", wr_log.size());
        end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_push_pop_full();
        int bad;
        apply_reset();
        for (int i = 0; i < 75; i++) step(1, 1, 1, 0);
        step(1, 1, 1, 1);
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL pp_ovf: got %b want 0", overflow); end
        vectors++; if (mem_addr !== 9'd1) begin miscompares++; $display("FAIL pp_head: got %0d want 1", mem_addr); end
        repeat (6) step(0, 0, 1, 1);
        bad = 0;
        for (int k = 0; k < wr_log.size(); k++) if (wr_log[k].a !== 9'(k)) bad++;
        vectors++; if (wr_log.size() != 5 || bad != 0) begin miscompares++; $display("FAIL pp_drain: got %0d writes %0d misaddressed want 5 0", wr_log.size(), bad); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] p;
        apply_reset();
        for (int i = 0; i < 7; i++) step(1, 1, 1, 1);
        reset = 0;
        #1;
        model_reset();
        vectors++;
        if (mem_we !== 0 || mem_addr !== 0 || mem_data !== 0 || map_done !== 0 || overflow !== 0 || busy !== 0) begin
            miscompares++; $display("FAIL midreset_outputs: got we %b addr %0d data %h done %b ovf %b busy %b want all 0", mem_we, mem_addr, mem_data, map_done, overflow, busy);
        end
        @(posedge clk);
        #1;
        reset = 1;
        wr_log.delete();
        p = 16'($urandom) & 16'hFF80;
        for (int i = 0; i < 16; i++) step(1, p[i], 1, 1);
        repeat (2) step(0, 0, 1, 1);
        vectors++;
        if (wr_log.size() != 1 || wr_log[0].a !== 9'd0 || wr_log[0].d !== p) begin
            miscompares++; $display("FAIL midreset_word: got %0d writes data %h want 1 write data %h", wr_log.size(), (wr_log.size() > 0) ? wr_log[0].d : 16'h0, p);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 14000; i++) begin
            bit v, b, s, r;
            v = ($urandom % 10) < 8;
            b = $urandom % 2;
            s = ($urandom % 16) != 0;
            r = (((i / 700) % 4) == 3) ? 1'b0 : (($urandom % 4) != 0);
            step(v, b, s, r);
            vectors++; if (mem_we !== (mq.size() != 0)) begin miscompares++; $display("FAIL rnd_we cyc %0d: got %b want %b", i, mem_we, mq.size() != 0); end
            vectors++; if (mem_addr !== h_a) begin miscompares++; $display("FAIL rnd_addr cyc %0d: got %0d want %0d", i, mem_addr, h_a); end
            vectors++; if (mem_data !== h_d) begin miscompares++; $display("FAIL rnd_data cyc %0d: got %h want %h", i, mem_data, h_d); end
            vectors++; if (overflow !== m_ovf) begin miscompares++; $display("FAIL rnd_ovf cyc %0d: got %b want %b", i, overflow, m_ovf); end
            vectors++; if (map_done !== m_done) begin miscompares++; $display("FAIL rnd_done cyc %0d: got %b want %b", i, map_done, m_done); end
            vectors++; if (busy !== (n != 0 || mq.size() != 0)) begin miscompares++; $display("FAIL rnd_busy cyc %0d: got %b want %b", i, busy, (n != 0 || mq.size() != 0)); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_word();
        test_alternate();
        test_start_gate();
        test_full_frame();
        test_overflow();
        test_push_pop_full();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
